// File: rtl/vram_pkg.sv
// Shared constants, FSM state type and address helper for the VRAM arbiter.
package vram_pkg;

  localparam int H_RES      = 640;
  localparam int V_RES      = 480;
  localparam int PIX_TOTAL  = H_RES * V_RES;
  localparam int ADDR_W     = 19;
  localparam int DATA_W     = 12;
  localparam int WBUF_DEPTH = 4;

  typedef enum logic {IDLE, WRITE} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

  // Linear frame-buffer address of an active pixel.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [9:0] h, input logic [9:0] v);
    return ADDR_W'(v) * ADDR_W'(H_RES) + ADDR_W'(h);
  endfunction

endpackage

// File: rtl/vram_wbuf.sv
// Small synchronous FIFO that posts writer requests until the VRAM port is free.
module vram_wbuf #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 31
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               pop_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted only when an entry leaves in the same cycle.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/vram_arbiter.sv
// Shares one single-port VRAM between the display reader and a pixel writer.
// Define VRAM_WBUF_EN to post writes through a small FIFO instead of a direct handshake.
module vram_arbiter
  import vram_pkg::*;
(
  input  logic              pclk,
  input  logic              reset_n,
  input  logic              valid,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              frame_done,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              wr_ack_q, wr_ack_d;
  logic              frame_done_q, frame_done_d;
  logic              s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic              pix_valid_q, pix_valid_d;
  logic [DATA_W-1:0] pix_data_q, pix_data_d;

  // Display read pipeline: address stage, RAM access stage, output stage.
  always_comb begin
    s1_valid_d   = valid;
    s2_valid_d   = s1_valid_q;
    pix_valid_d  = s2_valid_q;
    pix_data_d   = s2_valid_q ? mem_rdata : '0;
    frame_done_d = valid && (h_cnt == 10'(H_RES - 1)) && (v_cnt == 10'(V_RES - 1));
  end

`ifdef VRAM_WBUF_EN
  wr_entry_t                       head;
  logic                            fifo_full, fifo_empty, push, pop;
  logic [$clog2(WBUF_DEPTH+1)-1:0] fifo_count;

  assign pop  = !valid && !fifo_empty;
  assign push = wr_req && !wr_ack_q && (!fifo_full || pop);

  vram_wbuf #(
    .DEPTH (WBUF_DEPTH),
    .WIDTH ($bits(wr_entry_t))
  ) u_wbuf (
    .clk       (pclk),
    .rst_n     (reset_n),
    .push      (push),
    .push_data ({wr_addr, wr_data}),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_d     = pop ? WRITE : IDLE;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    wr_ack_d    = push;
    if (pop) begin
      mem_addr_d  = head.addr;
      mem_wdata_d = head.data;
      mem_we_d    = (head.addr < ADDR_W'(PIX_TOTAL));
    end
    if (valid) mem_addr_d = pix_addr(h_cnt, v_cnt);
  end

  assign busy = (fifo_count != '0) || (state_q == WRITE);
`else
  // The write is granted only from IDLE during blanking, so WRITE always follows a valid=0 cycle.
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    wr_ack_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!valid && wr_req) begin
          state_d     = WRITE;
          mem_addr_d  = wr_addr;
          mem_wdata_d = wr_data;
          mem_we_d    = (wr_addr < ADDR_W'(PIX_TOTAL));
          wr_ack_d    = 1'b1;
        end
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (valid) mem_addr_d = pix_addr(h_cnt, v_cnt);
  end

  assign busy = 1'b0;
`endif

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      wr_ack_q     <= 1'b0;
      frame_done_q <= 1'b0;
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      pix_valid_q  <= 1'b0;
      pix_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      wr_ack_q     <= wr_ack_d;
      frame_done_q <= frame_done_d;
      s1_valid_q   <= s1_valid_d;
      s2_valid_q   <= s2_valid_d;
      pix_valid_q  <= pix_valid_d;
      pix_data_q   <= pix_data_d;
    end
  end

  assign pix_data   = pix_data_q;
  assign pix_valid  = pix_valid_q;
  assign frame_done = frame_done_q;
  assign wr_ack     = wr_ack_q;
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomised bench for vram_arbiter (default build) against a cycle-rule reference model.
module tb_vram_arbiter;
  import vram_pkg::*;

  logic              pclk = 1'b0;
  logic              reset_n = 1'b0;
  logic              valid = 1'b0;
  logic [9:0]        h_cnt = '0, v_cnt = '0;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid, frame_done;
  logic              wr_req = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_ack, busy;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;

  int checks = 0;
  int passes = 0;

  logic [DATA_W-1:0] ram       [PIX_TOTAL];
  logic [DATA_W-1:0] model_mem [PIX_TOTAL];

  // Reference state: previous-cycle ack, expected port registers, 3-deep pixel delay line.
  bit                m_ack;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  bit                pv [3];
  logic [DATA_W-1:0] pd [3];
  bit                auto_writer = 1'b0;
  bit                allow_oob = 1'b0;
  int                we_seen, fd_seen;

  vram_arbiter dut (
    .pclk       (pclk),
    .reset_n    (reset_n),
    .valid      (valid),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .frame_done (frame_done),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .busy       (busy),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 pclk = ~pclk;

  // Behavioural single-port synchronous RAM: data appears one cycle after the address.
  always @(posedge pclk) begin
    int idx;
    idx = int'(mem_addr);
    if (mem_we && idx < PIX_TOTAL) ram[idx] <= mem_wdata;
    mem_rdata <= (idx < PIX_TOTAL) ? ram[idx] : '0;
  end

  function automatic logic [DATA_W-1:0] init_val(input int a);
    return DATA_W'((a * 37 + 5) ^ (a >> 7));
  endfunction

  function automatic logic [ADDR_W-1:0] rand_addr(input bit oob);
    if (oob && ($urandom_range(0, 5) == 0))
      return ADDR_W'($urandom_range(PIX_TOTAL, (1 << ADDR_W) - 1));
    return ADDR_W'($urandom_range(0, PIX_TOTAL - 1));
  endfunction

  task automatic checkOutput(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got == exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_ack   = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    for (int i = 0; i < 3; i++) begin
      pv[i] = 1'b0;
      pd[i] = '0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_pix_data"},  pix_data,   0);
    checkOutput({tag, "_pix_valid"}, pix_valid,  0);
    checkOutput({tag, "_frame_done"}, frame_done, 0);
    checkOutput({tag, "_wr_ack"},    wr_ack,     0);
    checkOutput({tag, "_busy"},      busy,       0);
    checkOutput({tag, "_mem_addr"},  mem_addr,   0);
    checkOutput({tag, "_mem_we"},    mem_we,     0);
    checkOutput({tag, "_mem_wdata"}, mem_wdata,  0);
  endtask

  // One clock: derive expectations from the rules, advance, compare.
  task automatic applyStimulus();
    bit   ack_n, we_n, fd_n;
    int   a;
    ack_n = !m_ack && !valid && wr_req;
    we_n  = ack_n && (int'(wr_addr) < PIX_TOTAL);
    fd_n  = valid && (int'(h_cnt) == H_RES - 1) && (int'(v_cnt) == V_RES - 1);
    a     = int'(v_cnt) * H_RES + int'(h_cnt);
    if (ack_n) begin
      m_addr  = wr_addr;
      m_wdata = wr_data;
    end
    if (valid) m_addr = ADDR_W'(a);
    if (we_n) model_mem[int'(wr_addr)] = wr_data;
    pv[2] = pv[1]; pd[2] = pd[1];
    pv[1] = pv[0]; pd[1] = pd[0];
    pv[0] = valid;
    pd[0] = valid ? model_mem[a] : '0;
    m_ack = ack_n;

    @(posedge pclk);
    #1;
    checkOutput("wr_ack",     wr_ack,     ack_n);
    checkOutput("mem_we",     mem_we,     we_n);
    checkOutput("mem_addr",   mem_addr,   m_addr);
    checkOutput("frame_done", frame_done, fd_n);
    checkOutput("pix_valid",  pix_valid,  pv[2]);
    checkOutput("pix_data",   pix_data,   pv[2] ? pd[2] : '0);
    checkOutput("busy",       busy,       0);
    if (we_n) checkOutput("mem_wdata", mem_wdata, m_wdata);
    if (mem_we) we_seen++;
    if (frame_done) fd_seen++;
    if (ack_n && auto_writer) begin
      wr_addr = rand_addr(allow_oob);
      wr_data = DATA_W'($urandom);
    end
  endtask

  initial begin
    for (int i = 0; i < PIX_TOTAL; i++) begin
      ram[i]       = init_val(i);
      model_mem[i] = init_val(i);
    end
    model_reset();

    // Reset held while the writer already requests.
    wr_req  = 1'b1;
    wr_addr = 19'd100;
    wr_data = 12'h123;
    repeat (2) @(posedge pclk);
    #1;
    check_reset_outputs("rst");
    reset_n = 1'b1;
    repeat (3) applyStimulus();
    wr_req = 1'b0;
    applyStimulus();

    // Single read at (5,2) with a known RAM word.
    ram[1285]       = 12'hABC;
    model_mem[1285] = 12'hABC;
    valid = 1'b1; h_cnt = 10'd5; v_cnt = 10'd2;
    applyStimulus();
    checkOutput("rd_addr_1285", mem_addr, 1285);
    valid = 1'b0;
    repeat (2) applyStimulus();
    checkOutput("rd_pix_abc", pix_data, 12'hABC);
    applyStimulus();

    // Writer waits through a full active line, then streams during blanking.
    wr_req = 1'b1; wr_addr = 19'd1000; wr_data = 12'h5A5;
    auto_writer = 1'b1; allow_oob = 1'b0;
    v_cnt = 10'd10;
    we_seen = 0;
    for (int h = 0; h < H_RES; h++) begin
      valid = 1'b1; h_cnt = 10'(h);
      applyStimulus();
    end
    checkOutput("no_we_active", we_seen, 0);
    valid = 1'b0;
    we_seen = 0;
    repeat (10) applyStimulus();
    checkOutput("blank_writes", we_seen, 5);
    wr_req = 1'b0; auto_writer = 1'b0;
    repeat (2) applyStimulus();

    // Out-of-range write is acknowledged but never reaches memory.
    wr_req = 1'b1; wr_addr = ADDR_W'(PIX_TOTAL); wr_data = 12'hFFF;
    we_seen = 0;
    applyStimulus();
    checkOutput("oob_ack", wr_ack, 1);
    wr_req = 1'b0;
    applyStimulus();
    checkOutput("oob_no_we", we_seen, 0);

    // End of frame pulse.
    fd_seen = 0;
    v_cnt = 10'd479;
    for (int h = 634; h < H_RES; h++) begin
      valid = 1'b1; h_cnt = 10'(h);
      applyStimulus();
    end
    valid = 1'b0;
    repeat (4) applyStimulus();
    checkOutput("fd_pulses", fd_seen, 1);

    // Reset in the middle of a write drops it.
    wr_req = 1'b1; wr_addr = 19'd777; wr_data = 12'h0F0;
    applyStimulus();
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge pclk);
    #1;
    reset_n = 1'b1;
    model_reset();
    wr_req = 1'b0;
    applyStimulus();

    // Randomised mix of active video and writer traffic.
    auto_writer = 1'b1; allow_oob = 1'b1;
    wr_addr = rand_addr(1'b1);
    wr_data = DATA_W'($urandom);
    for (int c = 0; c < 3000; c++) begin
      valid = ($urandom_range(0, 9) < 6);
      h_cnt = 10'($urandom_range(0, H_RES - 1));
      v_cnt = 10'($urandom_range(0, V_RES - 1));
      if (($urandom_range(0, 15) == 0)) begin
        h_cnt = 10'(H_RES - 1);
        v_cnt = 10'(V_RES - 1);
      end
      if (!wr_req) wr_req = ($urandom_range(0, 2) == 0);
      applyStimulus();
      if (m_ack) wr_req = $urandom_range(0, 1) != 0;
    end
    valid = 1'b0; wr_req = 1'b0;
    repeat (4) applyStimulus();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
